// File: rtl/set_bit_serializer_pkg.sv
// Shared types and defaults for the set-bit serializer slice.
package set_bit_serializer_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int POS_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    ZERO = 2'd2
  } state_e;

endpackage

// File: rtl/set_bit_serializer_lowest_one_enc.sv
// Combinational lowest-set-bit encoder; reports WIDTH-1 when nothing is set.
module lowest_one_enc #(
  parameter int WIDTH = 8,
  parameter int POS_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [POS_W-1:0] pos_o,
  output logic             found_o
);

  always_comb begin
    pos_o   = POS_W'(WIDTH - 1);
    found_o = 1'b0;
    // Scan downward so the last hit is the lowest set bit.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        pos_o   = POS_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/set_bit_serializer.sv
// Accepts a request vector and emits the index of each set bit, lowest first,
// one per output handshake; all-zero vectors produce a single flagged beat.
module set_bit_serializer
  import set_bit_serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] out_pos,
  output logic             out_none,
  output logic             out_last,
  output logic [POS_W:0]   out_idx,
  input  logic             abort
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] residual_q, residual_d;
  logic [POS_W:0]   idx_q, idx_d;

  logic [POS_W-1:0] enc_pos;
  logic             enc_found;
  logic [WIDTH-1:0] residual_clr;
  logic             single_bit;

  lowest_one_enc #(
    .WIDTH (WIDTH),
    .POS_W (POS_W)
  ) u_enc (
    .vec_i   (residual_q),
    .pos_o   (enc_pos),
    .found_o (enc_found)
  );

  // x & (x-1) drops the lowest set bit; a zero result means one bit remained.
  assign residual_clr = residual_q & (residual_q - WIDTH'(1));
  assign single_bit   = enc_found && (residual_clr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      residual_q <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
    idx_d      = idx_q;
    if (abort) begin
      state_d    = IDLE;
      residual_d = '0;
      idx_d      = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            residual_d = in_vec;
            idx_d      = '0;
            state_d    = (in_vec == '0) ? ZERO : SCAN;
          end
        end
        SCAN: begin
          if (out_ready) begin
            residual_d = residual_clr;
            idx_d      = idx_q + 1'b1;
            if (single_bit) state_d = IDLE;
          end
        end
        ZERO: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !reset;
    out_valid = (state_q == SCAN) || (state_q == ZERO);
    out_none  = (state_q == ZERO);
    out_last  = (state_q == ZERO) || ((state_q == SCAN) && single_bit);
    out_pos   = (state_q == IDLE) ? '0 : enc_pos;
    out_idx   = idx_q;
  end

endmodule

// File: tb/tb_set_bit_serializer.sv
// Directed bench for set_bit_serializer with hand-computed beat sequences.
module tb_set_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_pos;
  logic       out_none;
  logic       out_last;
  logic [3:0] out_idx;
  logic       abort;

  int n_tests = 0;
  int n_fail  = 0;

  set_bit_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pos   (out_pos),
    .out_none  (out_none),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input int pos, input int idx,
                          input logic last, input logic none);
    chk({tag, " valid"}, out_valid, 1'b1);
    chk({tag, " pos"}, out_pos, pos);
    chk({tag, " idx"}, out_idx, idx);
    chk({tag, " last"}, out_last, last);
    chk({tag, " none"}, out_none, none);
    chk({tag, " in_ready"}, in_ready, 1'b0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " out_valid"}, out_valid, 1'b0);
    chk({tag, " in_ready"}, in_ready, 1'b1);
  endtask

  task automatic send(input logic [7:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int a4_pos [3] = '{2, 5, 7};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    abort     = 1'b0;
    step();
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst out_valid", out_valid, 1'b0);
    reset = 1'b0;
    #1;
    chk_idle("post-rst");
    chk("post-rst pos", out_pos, 0);
    chk("post-rst idx", out_idx, 0);
    chk("post-rst last", out_last, 1'b0);
    chk("post-rst none", out_none, 1'b0);

    // 1010_0100 -> beats 2,5,7
    out_ready = 1'b1;
    send(8'hA4);
    for (int i = 0; i < 3; i++) begin
      chk_beat($sformatf("a4 beat%0d", i), a4_pos[i], i, (i == 2), 1'b0);
      step();
    end
    chk_idle("a4 done");

    // zero vector then 0x80
    send(8'h00);
    chk_beat("zero", 7, 0, 1'b1, 1'b1);
    step();
    chk_idle("zero done");
    send(8'h80);
    chk_beat("h80", 7, 0, 1'b1, 1'b0);
    step();
    chk_idle("h80 done");

    // all ones with stalls
    out_ready = 1'b0;
    send(8'hFF);
    for (int i = 0; i < 8; i++) begin
      chk_beat($sformatf("ff stall%0d", i), i, i, (i == 7), 1'b0);
      step();
      chk_beat($sformatf("ff hold%0d", i), i, i, (i == 7), 1'b0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk_idle("ff done");

    // abort wins over out_ready on first beat
    send(8'h81);
    chk_beat("h81", 0, 0, 1'b0, 1'b0);
    out_ready = 1'b1;
    abort     = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort");
    send(8'h02);
    chk_beat("h02", 1, 0, 1'b1, 1'b0);
    step();
    chk_idle("h02 done");

    // async reset mid-beat
    out_ready = 1'b0;
    send(8'h3C);
    chk_beat("h3c", 2, 0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst out_valid", out_valid, 1'b0);
    chk("arst in_ready", in_ready, 1'b0);
    step();
    #2 reset = 1'b0;
    #1;
    chk_idle("arst rel");
    step();
    chk_idle("arst no stale");

    // in_valid held high across two vectors
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_vec    = 8'h01;
    step();
    chk_beat("hold v1", 0, 0, 1'b1, 1'b0);
    in_vec = 8'h02;
    step();
    chk_idle("hold gap");
    step();
    in_valid = 1'b0;
    chk_beat("hold v2", 1, 0, 1'b1, 1'b0);
    step();
    chk_idle("hold done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
